// File: rtl/bitwise_pkg.sv
// bitwise_pkg: shared constants and helpers for the bitwise comparator slice.
//   DefaultWidth : default operand width
//   calc_dw()    : width needed to hold a popcount of 0..w
package bitwise_pkg;

  localparam int unsigned DefaultWidth = 2;

  function automatic int unsigned calc_dw(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bitwise_if.sv
// bitwise_if: operand/result bundle for the bitwise comparator.
//   x, y      : operands (driven by master)
//   z, gt, lt : equality / magnitude flags
//   and_o, or_o, xor_o : bitwise results
//   hdist     : Hamming distance of x and y
//   out_valid : results reflect sampled operands
// master = operand source / result consumer, slave = the comparator.
interface bitwise_if
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  localparam int unsigned DW = calc_dw(WIDTH);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             z;
  logic             gt;
  logic             lt;
  logic [WIDTH-1:0] and_o;
  logic [WIDTH-1:0] or_o;
  logic [WIDTH-1:0] xor_o;
  logic [DW-1:0]    hdist;
  logic             out_valid;

  modport master (
    output x, y,
    input  z, gt, lt, and_o, or_o, xor_o, hdist, out_valid
  );

  modport slave (
    input  x, y,
    output z, gt, lt, and_o, or_o, xor_o, hdist, out_valid
  );

endinterface

// File: rtl/bitwise_popcount.sv
// bitwise_popcount: combinational population count.
//   data  : WIDTH-bit input vector
//   count : number of set bits in data (DW bits, always fits 0..WIDTH)
module bitwise_popcount
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned DW = calc_dw(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [DW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + DW'(data[i]);
    end
  end

endmodule

// File: rtl/bitwise.sv
// bitwise: registered two-operand comparator / bitwise-logic unit.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : bitwise_if slave port (x, y in; z, gt, lt, and_o, or_o, xor_o,
//           hdist, out_valid out)
// All results are sampled every cycle with one cycle of latency and driven
// straight from flops.
module bitwise
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned DW = calc_dw(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  bitwise_if.slave bus
);

  logic [WIDTH-1:0] xor_d;
  logic [DW-1:0]    hdist_d;

  logic             z_q;
  logic             gt_q;
  logic             lt_q;
  logic [WIDTH-1:0] and_q;
  logic [WIDTH-1:0] or_q;
  logic [WIDTH-1:0] xor_q;
  logic [DW-1:0]    hdist_q;
  logic             valid_q;

  assign xor_d = bus.x ^ bus.y;

  bitwise_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .data  (xor_d),
    .count (hdist_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q     <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      and_q   <= '0;
      or_q    <= '0;
      xor_q   <= '0;
      hdist_q <= '0;
      valid_q <= 1'b0;
    end else begin
      z_q     <= (bus.x == bus.y);
      gt_q    <= (bus.x > bus.y);
      lt_q    <= (bus.x < bus.y);
      and_q   <= bus.x & bus.y;
      or_q    <= bus.x | bus.y;
      xor_q   <= xor_d;
      hdist_q <= hdist_d;
      valid_q <= 1'b1;
    end
  end

  assign bus.z         = z_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.and_o     = and_q;
  assign bus.or_o      = or_q;
  assign bus.xor_o     = xor_q;
  assign bus.hdist     = hdist_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_bitwise.sv
// tb_bitwise: self-checking bench for bitwise with a result scoreboard.
module tb_bitwise;

  localparam int unsigned W  = 2;
  localparam int unsigned DW = $clog2(W + 1);

  typedef struct packed {
    logic          z;
    logic          gt;
    logic          lt;
    logic [W-1:0]  and_o;
    logic [W-1:0]  or_o;
    logic [W-1:0]  xor_o;
    logic [DW-1:0] hdist;
    logic          out_valid;
  } res_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  res_t sbq[$];

  bitwise_if #(.WIDTH(W)) bus ();

  bitwise #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: unsigned compare, bitwise ops, popcount.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic rn);
    res_t r;
    r = '0;
    if (rn) begin
      r.z         = (a == b);
      r.gt        = (int'(a) > int'(b));
      r.lt        = (int'(a) < int'(b));
      r.and_o     = a & b;
      r.or_o      = a | b;
      r.xor_o     = a ^ b;
      r.hdist     = DW'($countones(a ^ b));
      r.out_valid = 1'b1;
    end
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r.z         = bus.z;
    r.gt        = bus.gt;
    r.lt        = bus.lt;
    r.and_o     = bus.and_o;
    r.or_o      = bus.or_o;
    r.xor_o     = bus.xor_o;
    r.hdist     = bus.hdist;
    r.out_valid = bus.out_valid;
    return r;
  endfunction

  // Drive one operand pair on the falling edge, push its expected result,
  // then advance to just after the sampling edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic rn);
    @(negedge clk);
    bus.x = a;
    bus.y = b;
    rst_n = rn;
    sbq.push_back(model(a, b, rn));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_t got, exp;
    for (int i = 0; i < 2; i++) begin
      step(2'd3, 2'd3, 1'b0);
      got = sample();
      exp = sbq.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got=%h want=%h", i, got, exp);
      end
    end
    step(2'd3, 2'd3, 1'b1);
    got = sample();
    exp = sbq.pop_front();
    total++;
    if (got !== exp || got.z !== 1'b1 || got.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_gt();
    res_t got, exp;
    step(2'd3, 2'd2, 1'b1);
    got = sample();
    exp = sbq.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL gt_3_2: got=%h want=%h", got, exp);
    end
    total++;
    if ({got.z, got.gt, got.lt, got.and_o, got.or_o, got.xor_o, got.hdist} !==
        {1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 2'd1, 2'd1}) begin
      bad++;
      $display("FAIL gt_3_2_const: got=%h", got);
    end
  endtask

  task automatic test_equal_b2b();
    res_t got, exp;
    logic [W-1:0] vals [2];
    vals[0] = 2'd3;
    vals[1] = 2'd1;
    for (int i = 0; i < 2; i++) begin
      step(vals[i], vals[i], 1'b1);
      got = sample();
      exp = sbq.pop_front();
      total++;
      if (got !== exp || got.z !== 1'b1 || got.gt !== 1'b0 || got.lt !== 1'b0 ||
          got.hdist !== '0 || got.xor_o !== '0) begin
        bad++;
        $display("FAIL equal_b2b[%0d]: got=%h want=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_lt();
    res_t got, exp;
    step(2'd1, 2'd2, 1'b1);
    got = sample();
    exp = sbq.pop_front();
    total++;
    if (got !== exp || {got.z, got.lt, got.and_o, got.or_o, got.xor_o, got.hdist} !==
        {1'b0, 1'b1, 2'd0, 2'd3, 2'd3, 2'd2}) begin
      bad++;
      $display("FAIL lt_1_2: got=%h want=%h", got, exp);
    end
    step(2'd1, 2'd3, 1'b1);
    got = sample();
    exp = sbq.pop_front();
    total++;
    if (got !== exp || {got.z, got.lt, got.and_o, got.or_o, got.xor_o, got.hdist} !==
        {1'b0, 1'b1, 2'd1, 2'd3, 2'd2, 2'd1}) begin
      bad++;
      $display("FAIL lt_1_3: got=%h want=%h", got, exp);
    end
  endtask

  // All 16 pairs back-to-back with a reset cycle injected mid-sweep. Also
  // checks outputs hold between edges after the inputs change.
  task automatic test_sweep();
    res_t got, exp, prev;
    prev = sample();
    for (int i = 0; i < 17; i++) begin
      logic [3:0] idx;
      logic       rn;
      rn  = (i != 8);
      idx = 4'((i > 8) ? i - 1 : i);
      @(negedge clk);
      bus.x = idx[3:2];
      bus.y = idx[1:0];
      rst_n = rn;
      sbq.push_back(model(idx[3:2], idx[1:0], rn));
      #1;
      got = sample();
      total++;
      if (got !== prev) begin
        bad++;
        $display("FAIL sweep_hold[%0d]: got=%h want=%h", i, got, prev);
      end
      @(posedge clk);
      #1;
      got = sample();
      exp = sbq.pop_front();
      prev = exp;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL sweep[%0d] x=%0d y=%0d rst_n=%0b: got=%h want=%h",
                 i, idx[3:2], idx[1:0], rn, got, exp);
      end
      if (got.out_valid === 1'b1) begin
        total++;
        if ((int'(got.z) + int'(got.gt) + int'(got.lt)) != 1 ||
            (got.z !== (got.hdist == '0 && got.xor_o == '0))) begin
          bad++;
          $display("FAIL sweep_invariant[%0d]: got=%h", i, got);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.x = '0;
    bus.y = '0;
    test_reset();
    test_gt();
    test_equal_b2b();
    test_lt();
    test_sweep();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitwise.md
Name: bitwise

Overview:
- Registered 2-operand comparator / bitwise-logic unit.
- Primary function: `z` flags whether operands `x` and `y` are equal.
- Auxiliary outputs give magnitude relation, bitwise AND/OR/XOR and Hamming distance.
- Sits as a leaf datapath block; all outputs update one clock after operands are sampled.

Parameters:
- WIDTH, 2, operand width in bits (must be >= 1).
- DW, $clog2(WIDTH+1), width of Hamming-distance output (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset; synchronous, active-low.
- x  input  WIDTH  operand A, unsigned.
- y  input  WIDTH  operand B, unsigned.
- z  output  1  registered equality flag: 1 when x == y.
- gt  output  1  registered: 1 when x > y (unsigned).
- lt  output  1  registered: 1 when x < y (unsigned).
- and_o  output  WIDTH  registered x & y.
- or_o  output  WIDTH  registered x | y.
- xor_o  output  WIDTH  registered x ^ y.
- hdist  output  DW  registered popcount(x ^ y).
- out_valid  output  1  high when outputs reflect sampled operands.

Behaviour:
- Clock and reset: one clock (`clk`); reset is synchronous and active-low (`rst_n`), sampled on the rising edge of `clk`.
- Reset values: while `rst_n` = 0 at a rising edge, all outputs load 0 (z=0, gt=0, lt=0, and_o/or_o/xor_o=0, hdist=0, out_valid=0).
- Sampling:
  - Every rising edge with `rst_n` = 1 samples x, y and registers all results.
  - Latency is 1 cycle; there is no input handshake.
  - Operands may change every cycle, giving full throughput.
- Relation flags: exactly one of z, gt, lt is 1 whenever out_valid = 1.
- Hamming distance: z = 1 if and only if hdist = 0 and xor_o = 0.
- out_valid: becomes 1 on the first rising edge after `rst_n` deasserts, and stays 1 until the next reset.
- Reset mid-operation: a low `rst_n` at any edge overrides sampling. Outputs go to reset values on that edge and the in-flight result is discarded.
- Arithmetic:
  - All comparisons are unsigned, at full WIDTH.
  - hdist never exceeds WIDTH and never overflows DW.
- X/Z on inputs: no special handling required; behaviour is undefined.
- Outputs are driven directly from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Package bitwise_pkg: default WIDTH constant and a function computing DW.
- One natural sub-module: bitwise_popcount, a parameterised combinational popcount (WIDTH in, DW out) used for hdist.
- Comparison and logic operations are computed inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with x=3, y=3 -> all outputs 0, out_valid=0. Release -> next edge gives z=1, out_valid=1.
- x=3, y=2 -> after 1 cycle: z=0, gt=1, lt=0, and_o=2, or_o=3, xor_o=1, hdist=1.
- x=3, y=3, then x=1, y=1 on consecutive cycles -> z=1 both cycles, gt=lt=0, hdist=0, xor_o=0.
- x=1, y=2 -> z=0, lt=1, and_o=0, or_o=3, xor_o=3, hdist=2.
- x=1, y=3 -> z=0, lt=1, and_o=1, or_o=3, xor_o=2, hdist=1.
- Exhaustive sweep of all 16 (x,y) pairs back-to-back: each result appears exactly 1 cycle after its inputs. Asserting rst_n=0 mid-sweep zeroes outputs on that edge, and the sweep resumes correctly after release.
